password_lock_param: RTL

//  Parametrised successor of the switch-entry password FSM for the FPGA practice boards. Turns switch

---
 rtl/password_lock_param.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/password_lock_param.sv
// Switch-entry password lock: synchronises raw switch levels, turns rising
// edges into digits, checks them against a programmable code and reports
// idle / error / done / in-process status with a failed-try lockout.
module password_lock_param #(
    parameter int                          N_SW         = 10,
    parameter int                          CODE_LEN     = 4,
    parameter int                          DIG_W        = 4,
    parameter logic [CODE_LEN*DIG_W-1:0]   DEFAULT_CODE = 16'h6102,
    parameter bit                          EARLY_FAIL   = 1'b1,
    parameter int                          MAX_TRIES    = 3,
    parameter int                          LOCK_CYC     = 50000000
) (
    input  logic                                clk,
    input  logic                                rst_a_p,
    input  logic [N_SW-1:0]                     switches,
    input  logic                                prog_req,
    output logic [1:0]                          status,
    output logic                                locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]      fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]       digit_idx
);

    localparam int CW = CODE_LEN * DIG_W;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_ERROR,
        S_LOCKOUT,
        S_UNLOCKED,
        S_PROGRAM
    } state_t;

    state_t          state, state_n;
    logic [N_SW-1:0] sw_p0, sw_p1, sw_p2;
    logic [N_SW-1:0] pulse;
    logic            ev, valid, wrong, last;
    logic [DIG_W-1:0] digit;
    logic [CW-1:0]   code, code_n, shadow, shadow_n;
    logic            mism, mism_n;
    logic [FW-1:0]   fcnt_n, fail_inc;
    logic [IW-1:0]   didx_n;
    logic [LW-1:0]   lcnt, lcnt_n;

    // Index of the highest set switch pulse; only meaningful for one-hot pulses.
    function automatic logic [DIG_W-1:0] sw_to_digit(input logic [N_SW-1:0] p);
        logic [DIG_W-1:0] d;
        d = '0;
        for (int i = 0; i < N_SW; i++)
            if (p[i]) d = DIG_W'(i);
        return d;
    endfunction

    // Stored digit at a position; positions past the code read as zero.
    function automatic logic [DIG_W-1:0] code_digit(input logic [CW-1:0] c,
                                                    input logic [IW-1:0] idx);
        if (int'(idx) < CODE_LEN) return c[int'(idx)*DIG_W +: DIG_W];
        return '0;
    endfunction

    // Failure counter increment that holds at MAX_TRIES.
    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        if (int'(v) >= MAX_TRIES) return v;
        return v + 1'b1;
    endfunction

    assign pulse    = sw_p1 & ~sw_p2;
    assign ev       = |pulse;
    assign valid    = $onehot(pulse);
    assign digit    = sw_to_digit(pulse);
    assign wrong    = !valid || (digit != code_digit(code, digit_idx));
    assign last     = (int'(digit_idx) == CODE_LEN - 1);
    assign fail_inc = sat_inc(fail_cnt);

    // Next-state, counter and code update logic; IDLE shares the ENTRY path
    // because digit_idx and the mismatch flag are always zero in IDLE.
    always_comb begin
        state_n  = state;
        didx_n   = digit_idx;
        fcnt_n   = fail_cnt;
        mism_n   = mism;
        lcnt_n   = lcnt;
        code_n   = code;
        shadow_n = shadow;
        case (state)
            S_IDLE, S_ENTRY: begin
                if (ev) begin
                    if ((EARLY_FAIL && wrong) || (last && (mism || wrong))) begin
                        fcnt_n = fail_inc;
                        didx_n = '0;
                        mism_n = 1'b0;
                        if (int'(fail_inc) == MAX_TRIES) begin
                            state_n = S_LOCKOUT;
                            lcnt_n  = '0;
                        end else begin
                            state_n = S_ERROR;
                        end
                    end else if (last) begin
                        state_n = S_UNLOCKED;
                        fcnt_n  = '0;
                        didx_n  = '0;
                        mism_n  = 1'b0;
                    end else begin
                        state_n = S_ENTRY;
                        didx_n  = digit_idx + 1'b1;
                        mism_n  = mism | wrong;
                    end
                end
            end
            S_ERROR: begin
                if (ev) state_n = S_IDLE;
            end
            S_LOCKOUT: begin
                if (lcnt == LW'(LOCK_CYC - 1)) begin
                    state_n = S_IDLE;
                    fcnt_n  = '0;
                    lcnt_n  = '0;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            S_UNLOCKED: begin
                fcnt_n = '0;
                if (prog_req) begin
                    state_n = S_PROGRAM;
                    didx_n  = '0;
                end else if (ev) begin
                    state_n = S_IDLE;
                end
            end
            S_PROGRAM: begin
                if (ev) begin
                    if (!valid) begin
                        state_n = S_IDLE;
                        didx_n  = '0;
                    end else begin
                        shadow_n[int'(digit_idx)*DIG_W +: DIG_W] = digit;
                        if (last) begin
                            code_n  = shadow_n;
                            state_n = S_IDLE;
                            didx_n  = '0;
                        end else begin
                            didx_n = digit_idx + 1'b1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        status = 2'd0;
        case (state)
            S_ERROR, S_LOCKOUT:   status = 2'd1;
            S_UNLOCKED:           status = 2'd2;
            S_ENTRY, S_PROGRAM:   status = 2'd3;
            default:              status = 2'd0;
        endcase
    end

    assign locked_out = (state == S_LOCKOUT);

    // Synchroniser/edge stages: sw_p0, sw_p1 form the 2-FF synchroniser, sw_p2 holds the previous level.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            sw_p0     <= '0;
            sw_p1     <= '0;
            sw_p2     <= '0;
            state     <= S_IDLE;
            digit_idx <= '0;
            fail_cnt  <= '0;
            mism      <= 1'b0;
            lcnt      <= '0;
            code      <= DEFAULT_CODE;
        end else begin
            sw_p0     <= switches;
            sw_p1     <= sw_p0;
            sw_p2     <= sw_p1;
            state     <= state_n;
            digit_idx <= didx_n;
            fail_cnt  <= fcnt_n;
            mism      <= mism_n;
            lcnt      <= lcnt_n;
            code      <= code_n;
        end
    end

    // Program shadow buffer; only read back after all digits have been written.
    always_ff @(posedge clk) begin
        shadow <= shadow_n;
    end

endmodule
